// File: rtl/frame_receiver.sv
// Receives an 8-byte status frame: resynchronises on CR LF, checks the fixed bytes and latches good frames.
// Optional inter-byte timeout enabled by defining FRAME_TIMEOUT_EN.
module frame_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk_9600,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic [7:0]       speed,
    output logic [7:0]       distance,
    output logic             direction,
    output logic [1:0]       degree_class,
    output logic             frame_valid,
    output logic             frame_error,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] error_count,
    output logic             synced,
    output logic [1:0]       state_dbg
);

    // rx_valid is a one-cycle strobe with no back-pressure: every strobed byte is consumed on that edge.
    typedef enum logic [1:0] {HUNT = 2'd0, GOT_CR = 2'd1, DATA = 2'd2} state_t;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    if (TIMEOUT_CYCLES < 1 || CNT_W < 1) begin : g_cfg_check
        $error("frame_receiver: TIMEOUT_CYCLES and CNT_W must be at least 1");
    end

    state_t           state, state_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       sh_speed, sh_speed_n, sh_dist, sh_dist_n;
    logic             sh_dir, sh_dir_n;
    logic [1:0]       sh_deg, sh_deg_n;
    logic [7:0]       speed_n, distance_n;
    logic             direction_n, fv_n, fe_n, byte_ok, abort;
    logic [1:0]       degree_n;
    logic [CNT_W-1:0] fc_n, ec_n;

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
`endif

    always_comb begin
        byte_ok = 1'b0;
        case (idx)
            3'd0, 3'd1:       byte_ok = 1'b1;
            3'd2:             byte_ok = !rx_data[7] && (rx_data[3:0] == 4'hA);
            3'd3, 3'd4, 3'd5: byte_ok = (rx_data == 8'h00);
            3'd6:             byte_ok = (rx_data == CR);
            default:          byte_ok = (rx_data == LF);
        endcase
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        sh_speed_n  = sh_speed;
        sh_dist_n   = sh_dist;
        sh_dir_n    = sh_dir;
        sh_deg_n    = sh_deg;
        speed_n     = speed;
        distance_n  = distance;
        direction_n = direction;
        degree_n    = degree_class;
        fv_n        = 1'b0;
        fe_n        = 1'b0;
        fc_n        = frame_count;
        ec_n        = error_count;
        abort       = 1'b0;
`ifdef FRAME_TIMEOUT_EN
        tmo_cnt_n   = '0;
`endif
        case (state)
            HUNT: begin
                if (rx_valid && rx_data == CR) state_n = GOT_CR;
            end
            GOT_CR: begin
                if (rx_valid) begin
                    if (rx_data == LF) begin
                        state_n = DATA;
                        idx_n   = 3'd0;
                    end else if (rx_data != CR) begin
                        state_n = HUNT;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    if (byte_ok) begin
                        case (idx)
                            3'd0:    sh_speed_n = rx_data;
                            3'd1:    sh_dist_n  = rx_data;
                            3'd2: begin
                                sh_dir_n = rx_data[6];
                                sh_deg_n = rx_data[5:4];
                            end
                            default: ;
                        endcase
                        if (idx == 3'd7) begin
                            // The trailing LF also serves as the sync for the next frame.
                            speed_n     = sh_speed;
                            distance_n  = sh_dist;
                            direction_n = sh_dir;
                            degree_n    = sh_deg;
                            fv_n        = 1'b1;
                            fc_n        = frame_count + 1'b1;
                            idx_n       = 3'd0;
                        end else begin
                            idx_n = idx + 3'd1;
                        end
                    end else begin
                        abort   = 1'b1;
                        state_n = (rx_data == CR) ? GOT_CR : HUNT;
                    end
                end
`ifdef FRAME_TIMEOUT_EN
                else if (idx != 3'd0) begin
                    if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        abort   = 1'b1;
                        state_n = HUNT;
                    end else begin
                        tmo_cnt_n = tmo_cnt + 1'b1;
                    end
                end
`endif
            end
            default: state_n = HUNT;
        endcase
        if (abort) begin
            fe_n       = 1'b1;
            idx_n      = 3'd0;
            sh_speed_n = 8'h00;
            sh_dist_n  = 8'h00;
            sh_dir_n   = 1'b0;
            sh_deg_n   = 2'd0;
            if (error_count != {CNT_W{1'b1}}) ec_n = error_count + 1'b1;
        end
    end

    always_ff @(posedge clk_9600) begin
        if (reset) begin
            state        <= HUNT;
            idx          <= 3'd0;
            sh_speed     <= 8'h00;
            sh_dist      <= 8'h00;
            sh_dir       <= 1'b0;
            sh_deg       <= 2'd0;
            speed        <= 8'h00;
            distance     <= 8'h00;
            direction    <= 1'b0;
            degree_class <= 2'd0;
            frame_valid  <= 1'b0;
            frame_error  <= 1'b0;
            frame_count  <= '0;
            error_count  <= '0;
`ifdef FRAME_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            sh_speed     <= sh_speed_n;
            sh_dist      <= sh_dist_n;
            sh_dir       <= sh_dir_n;
            sh_deg       <= sh_deg_n;
            speed        <= speed_n;
            distance     <= distance_n;
            direction    <= direction_n;
            degree_class <= degree_n;
            frame_valid  <= fv_n;
            frame_error  <= fe_n;
            frame_count  <= fc_n;
            error_count  <= ec_n;
`ifdef FRAME_TIMEOUT_EN
            tmo_cnt      <= tmo_cnt_n;
`endif
        end
    end

    assign synced    = (state == DATA);
    assign state_dbg = state;

endmodule

// File: tb/tb_frame_receiver.sv
// Directed and randomized bench for frame_receiver, checked against a byte-stream model of the frame rules.
module tb_frame_receiver;

    localparam int TMO   = 64;
    localparam int CNT_W = 8;

    logic             clk_9600 = 1'b0;
    logic             reset    = 1'b1;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_data  = 8'h00;
    logic [7:0]       speed, distance;
    logic             direction, frame_valid, frame_error, synced;
    logic [1:0]       degree_class, state_dbg;
    logic [CNT_W-1:0] frame_count, error_count;

    always #5 clk_9600 = ~clk_9600;

    frame_receiver #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
        .clk_9600     (clk_9600),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .speed        (speed),
        .distance     (distance),
        .direction    (direction),
        .degree_class (degree_class),
        .frame_valid  (frame_valid),
        .frame_error  (frame_error),
        .frame_count  (frame_count),
        .error_count  (error_count),
        .synced       (synced),
        .state_dbg    (state_dbg)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: sync is "a CR immediately followed by LF"; once synced, bytes collect into m_q.
    logic [7:0]       e_speed = 8'h00, e_dist = 8'h00;
    logic             e_dir = 1'b0, e_fv = 1'b0, e_fe = 1'b0;
    logic [1:0]       e_deg = 2'd0;
    logic [CNT_W-1:0] e_fc = '0, e_ec = '0;
    bit               m_synced = 1'b0, m_prev_cr = 1'b0;
    int               m_idle = 0;
    logic [7:0]       m_q[$];
    logic [18:0]      exp_q[$];

    function automatic bit byte_ok(int pos, logic [7:0] b);
        case (pos)
            0, 1:    return 1'b1;
            2:       return (b[7] == 1'b0) && (b[3:0] == 4'hA);
            3, 4, 5: return b == 8'h00;
            6:       return b == 8'h0D;
            default: return b == 8'h0A;
        endcase
    endfunction

    task automatic model_abort(input logic [7:0] b, input bit is_byte);
        e_fe = 1'b1;
        if (e_ec != {CNT_W{1'b1}}) e_ec = e_ec + 1'b1;
        m_synced  = 1'b0;
        m_prev_cr = is_byte && (b == 8'h0D);
        m_q.delete();
        m_idle = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        e_fv   = 1'b0;
        e_fe   = 1'b0;
        m_idle = 0;
        if (!m_synced) begin
            if (m_prev_cr && b == 8'h0A) begin
                m_synced = 1'b1;
                m_q.delete();
            end
            m_prev_cr = (b == 8'h0D);
        end else if (byte_ok(m_q.size(), b)) begin
            m_q.push_back(b);
            if (m_q.size() == 8) begin
                logic [7:0] st;
                st      = m_q[2];
                e_speed = m_q[0];
                e_dist  = m_q[1];
                e_dir   = st[6];
                e_deg   = st[5:4];
                e_fc    = e_fc + 1'b1;
                e_fv    = 1'b1;
                exp_q.push_back({e_speed, e_dist, e_dir, e_deg});
                m_q.delete();
            end
        end else begin
            model_abort(b, 1'b1);
        end
    endtask

    task automatic model_idle();
        e_fv = 1'b0;
        e_fe = 1'b0;
`ifdef FRAME_TIMEOUT_EN
        if (m_synced && m_q.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) model_abort(8'h00, 1'b0);
        end else begin
            m_idle = 0;
        end
`endif
    endtask

    task automatic model_reset();
        e_speed = 8'h00; e_dist = 8'h00; e_dir = 1'b0; e_deg = 2'd0;
        e_fv = 1'b0; e_fe = 1'b0; e_fc = '0; e_ec = '0;
        m_synced = 1'b0; m_prev_cr = 1'b0; m_idle = 0;
        m_q.delete();
        exp_q.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, " frame_valid"},  32'(frame_valid),  32'(e_fv));
        chk({ctx, " frame_error"},  32'(frame_error),  32'(e_fe));
        chk({ctx, " synced"},       32'(synced),       32'(m_synced));
        chk({ctx, " speed"},        32'(speed),        32'(e_speed));
        chk({ctx, " distance"},     32'(distance),     32'(e_dist));
        chk({ctx, " direction"},    32'(direction),    32'(e_dir));
        chk({ctx, " degree_class"}, 32'(degree_class), 32'(e_deg));
        chk({ctx, " frame_count"},  32'(frame_count),  32'(e_fc));
        chk({ctx, " error_count"},  32'(error_count),  32'(e_ec));
        if (frame_valid && exp_q.size() > 0) begin
            logic [18:0] f;
            f = exp_q.pop_front();
            chk({ctx, " sb_frame"}, 32'({speed, distance, direction, degree_class}), 32'(f));
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk_9600);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        model_byte(b);
        check_all($sformatf("byte %02h", b));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_9600);
            #1;
            model_idle();
            check_all("idle");
        end
    endtask

    task automatic do_reset(input logic v, input logic [7:0] b);
        reset    = 1'b1;
        rx_valid = v;
        rx_data  = b;
        @(posedge clk_9600);
        #1;
        reset    = 1'b0;
        rx_valid = 1'b0;
        model_reset();
        check_all("reset");
    endtask

    task automatic sync();
        send(8'h0D);
        send(8'h0A);
    endtask

    task automatic build_frame(input logic [7:0] sp, input logic [7:0] di, input logic dir,
                               input logic [1:0] deg, output logic [7:0] f [8]);
        f = '{sp, di, {1'b0, dir, deg, 4'hA}, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h0A};
    endtask

    task automatic send_frame(input logic [7:0] sp, input logic [7:0] di, input logic dir,
                              input logic [1:0] deg, input int max_gap);
        logic [7:0] f [8];
        build_frame(sp, di, dir, deg, f);
        for (int i = 0; i < 8; i++) begin
            send(f[i]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    initial begin
        logic [7:0] f [8];

        do_reset(1'b0, 8'h00);

        // Reference frame: speed 0x32, distance 0x14, direction 1, class 1.
        sync();
        send_frame(8'h32, 8'h14, 1'b1, 2'd1, 0);

        // Two back-to-back frames on the same sync.
        send_frame(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), 0);
        send_frame(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), 0);

        // Bad byte 3 aborts to HUNT, fields held.
        send(8'h10); send(8'h20); send(8'h5A); send(8'h07);
        idle(3);

        // CR at index 3 aborts straight into GOT_CR.
        sync();
        send(8'h11); send(8'h22); send(8'h6A); send(8'h0D);
        send(8'h0A);
        send_frame(8'hA5, 8'h5A, 1'b0, 2'd2, 0);
        idle(5);

        // Reset mid-frame, with a CR strobed in the reset cycle.
        send(8'h01); send(8'h02); send(8'h1A); send(8'h00); send(8'h00);
        do_reset(1'b1, 8'h0D);
        send(8'h0A);
        sync();
        send_frame(8'h77, 8'h88, 1'b1, 2'd0, 0);

        // Long gap after byte 2 of a frame, then the rest of it.
        build_frame(8'h44, 8'h55, 1'b0, 2'd1, f);
        send(f[0]); send(f[1]); send(f[2]);
        idle(TMO + 6);
        for (int i = 3; i < 8; i++) send(f[i]);
        idle(2);

        // error_count saturation.
        for (int i = 0; i < 260; i++) begin
            sync();
            send(8'h11); send(8'h22); send(8'hFF);
        end

        // frame_count wrap.
        sync();
        for (int i = 0; i < 260; i++) send_frame(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), 0);

        do_reset(1'b0, 8'h00);

        // Randomized traffic: good and corrupted frames, junk, gaps, resyncs.
        for (int it = 0; it < 250; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                build_frame(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), f);
                if ($urandom_range(0, 9) < 3) f[$urandom_range(0, 7)] = 8'($urandom);
                for (int i = 0; i < 8; i++) begin
                    send(f[i]);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
                end
            end else if (r == 6) begin
                repeat ($urandom_range(1, 4)) send(8'($urandom));
            end else if (r == 7) begin
                idle($urandom_range(0, 5));
            end else if (r == 8) begin
                sync();
            end else if ($urandom_range(0, 4) == 0) begin
                do_reset(1'($urandom), 8'($urandom));
            end else begin
                send(8'h0D);
            end
        end

        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_receiver.md
FRAME_RECEIVER -- requirements
Module: frame_receiver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, meaning clk_9600 cycles allowed between accepted bytes inside a frame (used only when FRAME_TIMEOUT_EN is defined).
REQ-002 Parameter CNT_W, default 8, meaning width of frame_count and error_count.
REQ-003 clk_9600  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_valid  input  1  one-cycle strobe; rx_data holds a received UART byte.
REQ-006 rx_data  input  8  received byte, sampled only when rx_valid=1.
REQ-007 speed  output  8  speed field (byte 0) of the last good frame.
REQ-008 distance  output  8  distance field (byte 1) of the last good frame.
REQ-009 direction  output  1  bit 6 of byte 2 of the last good frame.
REQ-010 degree_class  output  2  bits 5:4 of byte 2 of the last good frame (0: <=80, 1: 81-100, 2: >100).
REQ-011 frame_valid  output  1  one-cycle pulse: a good frame was latched.
REQ-012 frame_error  output  1  one-cycle pulse: a frame was aborted.
REQ-013 frame_count  output  CNT_W  good frames since reset, wraps modulo 2^CNT_W.
REQ-014 error_count  output  CNT_W  aborted frames since reset, saturates at all-ones.
REQ-015 synced  output  1  high while in DATA state.

Function
REQ-016 Frame: 8 bytes, index 0..7 = speed, distance, status, 0x00, 0x00, 0x00, 0x0D, 0x0A; status byte = {1'b0, direction, degree_class, 4'b1010}.
REQ-017 States: HUNT, GOT_CR, DATA; byte index idx (3 bits) valid in DATA only.
REQ-018 HUNT: rx_valid with 0x0D -> GOT_CR; any other byte stays HUNT.
REQ-019 GOT_CR: 0x0A -> DATA with idx=0; 0x0D stays GOT_CR; other byte -> HUNT; no error pulses in HUNT/GOT_CR.
REQ-020 DATA: each rx_valid byte checked against REQ-016 at current idx; bytes 0-1 any value; byte 2 must have bit7=0 and bits3:0=1010; bytes 3-5 must be 0x00; byte 6 must be 0x0D; byte 7 must be 0x0A.
REQ-021 DATA matching byte at idx<7: store byte in shadow register, idx increments.
REQ-022 DATA matching byte at idx=7: next cycle frame_valid=1, speed/distance/direction/degree_class update from shadow registers, frame_count increments; state returns to DATA with idx=0 (terminator doubles as sync).
REQ-023 DATA mismatch: next cycle frame_error=1, error_count increments, shadow discarded, outputs unchanged; next state GOT_CR if mismatching byte is 0x0D, else HUNT.
REQ-024 Output fields hold their value between good frames; never partially updated.
REQ-025 frame_valid and frame_error never asserted in the same cycle; each is exactly one cycle wide.
REQ-026 Cycles without rx_valid change no state except the timeout counter (REQ-030).

Reset
REQ-027 reset=1 forces state HUNT, idx=0, all outputs and shadow registers to 0, counters to 0, timeout counter to 0.
REQ-028 reset mid-frame discards the partial frame without frame_error; reset has priority over rx_valid in the same cycle.

Configuration
REQ-029 Macro FRAME_TIMEOUT_EN selects the inter-byte timeout.
REQ-030 Defined: in DATA with idx!=0, counter increments each cycle without rx_valid, clears on rx_valid; reaching TIMEOUT_CYCLES aborts as REQ-023 (next state HUNT), counter clears.
REQ-031 Not defined: no timeout counter exists; DATA waits indefinitely for the next byte.

Verification
REQ-032 After reset, bytes 0D 0A 32 14 5A 00 00 00 0D 0A -> one frame_valid, speed=0x32, distance=0x14, direction=1, degree_class=1, frame_count=1.
REQ-033 Two back-to-back good frames after one sync -> two frame_valid pulses, frame_count=2, no frame_error.
REQ-034 Synced, bytes 10 20 5A 07 -> frame_error one cycle after 07, error_count=1, outputs keep prior values, synced=0.
REQ-035 Byte 6 replaced by 0x0D at index 3 -> frame_error, state GOT_CR; following 0A then good frame -> frame_valid.
REQ-036 reset asserted after byte 4 of a frame -> all outputs 0, no pulses; subsequent 0D 0A plus good frame -> frame_valid.
REQ-037 With FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=64, 64 idle cycles after byte 2 -> frame_error, synced=0; without macro -> no error, frame completes when remaining bytes arrive.
